// File: rtl/gf_sideband_pkg.sv
// Shared constants for the fit-pipeline sideband delay line.
// Holds the default storage depth, its select width, the depth select that
// matches the fit arithmetic latency, and the bit positions of the standard
// sideband channels inside the packed sideband bus.
package gf_sideband_pkg;

  localparam int MAX_DEPTH_DEFAULT = 32;
  localparam int DEPTH_W_DEFAULT   = $clog2(MAX_DEPTH_DEFAULT);

  // Depth select 22 gives a 23-cycle delay, which is the fit pipeline latency.
  localparam int DEFAULT_SEL_FIT   = 22;

  // Channel indices inside din/dout (channel i = bus[i*WIDTH +: WIDTH]).
  localparam int CH_VALID          = 0;
  localparam int CH_EE             = 1;
  localparam int CH_LAST_COMB      = 2;

endpackage

// File: rtl/sideband_ring_mem.sv
// Storage array for the sideband delay line.
// Ports:
//   clock  - rising-edge clock
//   we     - write enable for this edge
//   waddr  - write index
//   wdata  - word written at waddr when we=1
//   raddr  - read index (asynchronous read)
//   rdata  - word at raddr
// The array has no reset; stale contents are masked by the owner.
module sideband_ring_mem #(
  parameter int DW    = 3,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/shift_comb_sideband_delay.sv
// Programmable delay line for per-combination sideband flags.
// Keeps valid / end-event / last-combination (and any extra tag bits) aligned
// with the fit arithmetic pipeline. Delay = cur_sel+1 enabled cycles.
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-high; priority over ce and depth_load
//   ce         - shift enable; 0 freezes the whole line
//   depth_sel  - new depth select
//   depth_load - one-cycle strobe that latches depth_sel and restarts filling
//   din        - sideband input, NCH channels of WIDTH bits
//   dout       - delayed sideband, zero until the line is primed
//   primed     - dout carries real delayed data
//   cur_sel    - active depth select
module shift_comb_sideband_delay
  import gf_sideband_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int WIDTH       = 1,
  parameter int MAX_DEPTH   = MAX_DEPTH_DEFAULT,
  parameter int DEPTH_W     = $clog2(MAX_DEPTH),
  parameter int DEFAULT_SEL = DEFAULT_SEL_FIT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [DEPTH_W-1:0]     depth_sel,
  input  logic                   depth_load,
  input  logic [NCH*WIDTH-1:0]   din,
  output logic [NCH*WIDTH-1:0]   dout,
  output logic                   primed,
  output logic [DEPTH_W-1:0]     cur_sel
);

  localparam int DW = NCH * WIDTH;
  // Fill needs one extra bit so it can reach MAX_DEPTH itself.
  localparam int FW = DEPTH_W + 1;

  logic [DEPTH_W-1:0] wptr_q,    wptr_d;
  logic [DEPTH_W-1:0] cur_sel_q, cur_sel_d;
  logic [FW-1:0]      fill_q,    fill_d;
  logic [DEPTH_W-1:0] rd_idx;
  logic [DW-1:0]      rdata;
  logic               mem_we;

  function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
    return (f == FW'(MAX_DEPTH)) ? f : f + FW'(1);
  endfunction

  // Next-state: pointer advance, fill tracking, depth reload.
  always_comb begin
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    cur_sel_d = cur_sel_q;
    if (ce) begin
      wptr_d = wptr_q + DEPTH_W'(1);
      fill_d = fill_sat_inc(fill_q);
    end
    // A reload restarts the fill count; a sample written on the same edge
    // is the first sample of the new stream.
    if (depth_load) begin
      cur_sel_d = depth_sel;
      fill_d    = ce ? FW'(1) : '0;
    end
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q    <= '0;
      fill_q    <= '0;
      cur_sel_q <= DEPTH_W'(DEFAULT_SEL);
    end else begin
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Storage stage: reset blocks the write so it keeps priority over ce.
  assign mem_we = ce & ~reset;

  sideband_ring_mem #(
    .DW    (DW),
    .DEPTH (MAX_DEPTH),
    .AW    (DEPTH_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rd_idx),
    .rdata (rdata)
  );

  // Output stage: wptr points at the next free slot, so the newest sample is
  // at wptr-1 and the one A edges older is at wptr-1-A (modulo wrap).
  assign rd_idx  = wptr_q - DEPTH_W'(1) - cur_sel_q;
  assign primed  = (fill_q >= ({1'b0, cur_sel_q} + FW'(1)));
  assign dout    = primed ? rdata : '0;
  assign cur_sel = cur_sel_q;

endmodule

// File: tb/tb_shift_comb_sideband_delay.sv
// Self-checking bench for shift_comb_sideband_delay (NCH=3, WIDTH=2, depth 32).
// The reference keeps the history of samples accepted since the last reset
// or depth load; the expected output is the sample cur_sel entries back from
// the newest one, or zero while fewer than cur_sel+1 samples exist.
module tb_shift_comb_sideband_delay;
  import gf_sideband_pkg::*;

  localparam int NCH = 3;
  localparam int WIDTH = 2;
  localparam int MAXD = 32;
  localparam int DW = NCH * WIDTH;

  logic          clock;
  logic          reset;
  logic          ce;
  logic [4:0]    depth_sel;
  logic          depth_load;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          primed;
  logic [4:0]    cur_sel;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] hist[$];
  int            m_sel = DEFAULT_SEL_FIT;
  logic          exp_primed;
  logic [DW-1:0] exp_dout;

  shift_comb_sideband_delay #(
    .NCH(NCH), .WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DEFAULT_SEL(DEFAULT_SEL_FIT)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .depth_sel(depth_sel),
    .depth_load(depth_load), .din(din), .dout(dout), .primed(primed),
    .cur_sel(cur_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one clock edge and advance the reference history.
  task automatic step(input logic c, input logic [DW-1:0] d, input logic ld,
                      input logic [4:0] s, input logic r);
    ce = c; din = d; depth_load = ld; depth_sel = s; reset = r;
    @(posedge clock);
    #1;
    if (r) begin
      hist.delete();
      m_sel = DEFAULT_SEL_FIT;
    end else begin
      if (ld) begin
        hist.delete();
        m_sel = int'(s);
      end
      if (c) begin
        hist.push_back(d);
        if (hist.size() > 2 * MAXD) void'(hist.pop_front());
      end
    end
    exp_primed = (hist.size() >= m_sel + 1);
    exp_dout   = exp_primed ? hist[hist.size() - 1 - m_sel] : '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b1);
      tests_run++;
      if (dout !== '0 || primed !== 1'b0 || cur_sel !== 5'd22) begin
        tests_failed++;
        $display("FAIL reset_state cyc%0d: dout=%h primed=%b cur_sel=%0d, want 0/0/22", i, dout, primed, cur_sel);
      end
    end
    for (int k = 1; k <= 23; k++) begin
      step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (primed !== (k == 23) || dout !== exp_dout) begin
        tests_failed++;
        $display("FAIL prime_rise edge%0d: primed=%b dout=%h, want %b/%h", k, primed, dout, k == 23, exp_dout);
      end
    end
  endtask

  task automatic test_default_delay();
    logic [DW-1:0] pulse;
    pulse = DW'(1) << (CH_VALID * WIDTH);
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    for (int k = 1; k <= 80; k++) begin
      step(1'b1, (k == 40) ? pulse : '0, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== ((k == 62) ? pulse : '0)) begin
        tests_failed++;
        $display("FAIL default_delay edge%0d: dout=%h want %h", k, dout, (k == 62) ? pulse : '0);
      end
    end
  endtask

  task automatic test_stall();
    int obs_val[$];
    int obs_cyc[$];
    logic          c;
    logic [DW-1:0] d;
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    // cycles 0..29 zeros, 30..33 tagged 0..3, 34..38 zeros, 39..43 stalled, rest zeros
    for (int n = 0; n < 84; n++) begin
      c = !(n >= 39 && n <= 43);
      d = '0;
      if (n >= 30 && n <= 33)
        d = DW'(n - 30) | (DW'(1) << (CH_EE * WIDTH));
      else if (!c)
        d = DW'($urandom);
      step(c, d, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== exp_dout || primed !== exp_primed) begin
        tests_failed++;
        $display("FAIL stall_model cyc%0d: dout=%h primed=%b want %h/%b", n, dout, primed, exp_dout, exp_primed);
      end
      if (dout[CH_EE*WIDTH +: WIDTH] == 2'd1) begin
        obs_val.push_back(int'(dout[CH_VALID*WIDTH +: WIDTH]));
        obs_cyc.push_back(n);
      end
    end
    tests_run++;
    if (obs_val.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d tagged samples want 4", obs_val.size());
    end
    for (int j = 0; j < 4 && j < obs_val.size(); j++) begin
      tests_run++;
      if (obs_val[j] != j || obs_cyc[j] != 30 + j + 22 + 5) begin
        tests_failed++;
        $display("FAIL stall_order %0d: val=%0d cyc=%0d want %0d/%0d", j, obs_val[j], obs_cyc[j], j, 57 + j);
      end
    end
  endtask

  task automatic test_extremes();
    logic [DW-1:0] d0;
    logic [DW-1:0] d;
    logic          c;
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    d0 = DW'($urandom);
    step(1'b1, d0, 1'b1, 5'd0, 1'b0);
    tests_run++;
    if (primed !== 1'b1 || dout !== d0 || cur_sel !== 5'd0) begin
      tests_failed++;
      $display("FAIL sel0_load: dout=%h primed=%b cur_sel=%0d want %h/1/0", dout, primed, cur_sel, d0);
    end
    for (int k = 0; k < 20; k++) begin
      d = DW'($urandom);
      step(1'b1, d, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== d) begin
        tests_failed++;
        $display("FAIL sel0_delay %0d: dout=%h want %h", k, dout, d);
      end
    end
    d0 = DW'($urandom);
    step(1'b1, d0, 1'b1, 5'd31, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (primed !== (k == 31) || (k == 31 && dout !== d0)) begin
        tests_failed++;
        $display("FAIL sel31_delay edge%0d: primed=%b dout=%h want %b/%h", k, primed, dout, k == 31, d0);
      end
    end
    for (int k = 0; k < 100 * MAXD; k++) begin
      c = ($urandom_range(0, 7) != 0);
      step(c, DW'($urandom), 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== exp_dout || primed !== exp_primed) begin
        tests_failed++;
        $display("FAIL wrap_random %0d: dout=%h primed=%b want %h/%b", k, dout, primed, exp_dout, exp_primed);
      end
    end
  endtask

  task automatic test_reload();
    logic [DW-1:0] d0;
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 40; k++) step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b0);
    tests_run++;
    if (cur_sel !== 5'd22 || primed !== 1'b1 || dout !== exp_dout) begin
      tests_failed++;
      $display("FAIL reload_before: cur_sel=%0d primed=%b dout=%h want 22/1/%h", cur_sel, primed, dout, exp_dout);
    end
    d0 = DW'($urandom);
    step(1'b1, d0, 1'b1, 5'd5, 1'b0);
    tests_run++;
    if (primed !== 1'b0 || dout !== '0 || cur_sel !== 5'd5) begin
      tests_failed++;
      $display("FAIL reload_edge: primed=%b dout=%h cur_sel=%0d want 0/0/5", primed, dout, cur_sel);
    end
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (primed !== (k == 5) || dout !== ((k == 5) ? d0 : '0)) begin
        tests_failed++;
        $display("FAIL reload_latency edge%0d: primed=%b dout=%h want %b/%h", k, primed, dout, k == 5, (k == 5) ? d0 : '0);
      end
    end
    for (int k = 0; k < 30; k++) begin
      step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== exp_dout) begin
        tests_failed++;
        $display("FAIL reload_stream %0d: dout=%h want %h", k, dout, exp_dout);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] pulse;
    logic [DW-1:0] mark;
    pulse = DW'(1) << (CH_VALID * WIDTH);
    mark  = DW'(1) << (CH_LAST_COMB * WIDTH);
    step(1'b0, '0, 1'b0, 5'd0, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      step(1'b1, (k > 30 && (k % 2) == 1) ? pulse : '0, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== '0) begin
        tests_failed++;
        $display("FAIL reset_mid_pre edge%0d: dout=%h want 0", k, dout);
      end
    end
    step(1'b1, DW'($urandom), 1'b0, 5'd0, 1'b1);
    tests_run++;
    if (dout !== '0 || primed !== 1'b0 || cur_sel !== 5'd22) begin
      tests_failed++;
      $display("FAIL reset_mid_pulse: dout=%h primed=%b cur_sel=%0d want 0/0/22", dout, primed, cur_sel);
    end
    for (int k = 1; k <= 60; k++) begin
      step(1'b1, (k == 1) ? mark : '0, 1'b0, 5'd0, 1'b0);
      tests_run++;
      if (dout !== ((k == 23) ? mark : '0)) begin
        tests_failed++;
        $display("FAIL reset_mid_post edge%0d: dout=%h want %h", k, dout, (k == 23) ? mark : '0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; din = '0; depth_load = 1'b0; depth_sel = '0;
    test_reset();
    test_default_delay();
    test_stall();
    test_extremes();
    test_reload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_comb_sideband_delay.md
# shift_comb_sideband_delay

Parametrised delay line for per-combination sideband flags (valid, end-event, last-combination, plus any extra tag bits) that must stay aligned with the fit arithmetic pipeline. It replaces fixed-depth, fixed-three-bit shift registers with several channels of configurable width. The delay is programmable at run time, a clock enable stalls the line together with the datapath, and a fill tracker masks stale contents after reset or a depth change. The block sits beside the combination/fit pipeline and delays sideband bits by the pipeline latency.

## Interface
- NCH, 3: number of independent sideband channels
- WIDTH, 1: bits per channel
- MAX_DEPTH, 32: storage depth; power of two, 2..64
- DEPTH_W, $clog2(MAX_DEPTH): width of the depth select
- DEFAULT_SEL, 22: depth select loaded at reset (delay 23)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ce  in  1  shift enable; 0 freezes the whole line
- depth_sel  in  DEPTH_W  new depth select; delay = depth_sel+1 enabled cycles
- depth_load  in  1  one-cycle strobe; latches depth_sel
- din  in  NCH*WIDTH  sideband input; channel i = din[i*WIDTH +: WIDTH]
- dout  out  NCH*WIDTH  delayed sideband
- primed  out  1  high when dout carries real delayed data
- cur_sel  out  DEPTH_W  active depth select

## Operation
- Storage is a circular buffer with MAX_DEPTH entries of NCH*WIDTH bits and a write pointer wptr.
- Enabled edge (ce=1, reset=0): mem[wptr] <= din; wptr <= wptr+1, wrapping modulo MAX_DEPTH.
- Read index = wptr-1-A modulo MAX_DEPTH, where A = cur_sel. Wrap-around is natural because MAX_DEPTH is a power of two.
- Fill counter fill (0..MAX_DEPTH, saturating) counts enabled edges since the last reset or depth load.
- primed = (fill >= A+1).
- dout = primed ? mem[read index] : 0. All channels are masked together.
- ce=0: no write, wptr and fill hold, dout and primed hold.
- depth_load=1: cur_sel <= depth_sel and fill is cleared. If ce=1 on the same edge, the din of that edge is written and counts as fill=1. Buffer contents are not erased, only masked.
- reset: wptr=0, fill=0, cur_sel=DEFAULT_SEL. Outputs: dout=0, primed=0, cur_sel=DEFAULT_SEL. Reset has priority over ce and depth_load. The buffer is not cleared; masking covers stale data.
- Reset or depth load mid-stream: everything in flight is dropped (masked). The line restarts cleanly from the next enabled edge.

## Timing
- Latency: din sampled at enabled edge e0 appears on dout after enabled edge e0+A, i.e. A+1 enabled cycles. A=0 gives 1 cycle; A=22 gives 23; A=MAX_DEPTH-1 gives MAX_DEPTH.
- dout is decoded combinationally from registered storage and the registered fill/cur_sel, so it is valid right after the clock edge.
- primed rises after the (A+1)th enabled edge following reset or load. The first primed dout is the first sample written after that reset or load.
- Stall: k cycles of ce=0 add exactly k cycles of latency. Sample order is preserved.
- cur_sel updates on the edge after depth_load.

## Structure
- Shared package gf_sideband_pkg holds MAX_DEPTH_DEFAULT, DEPTH_W_DEFAULT, DEFAULT_SEL_FIT (22), and channel index constants (CH_VALID=0, CH_EE=1, CH_LAST_COMB=2).
- One sub-module, sideband_ring_mem: the storage array with write port and asynchronous read port. The pointer, fill and mask logic stays in the top level.

## Test plan
- Reset check: assert reset for 3 cycles with random din -> dout=0, primed=0, cur_sel=22 every cycle; primed first rises on the 23rd enabled edge after release.
- Default delay, ce=1: one-cycle pulse on valid (channel 0) at enabled edge 40 -> dout[0] high for exactly one cycle, after edge 62; ee and last_comb stay 0.
- Stall: ce low for 5 cycles, mid-flight of a tagged pattern 0,1,2,3 on a WIDTH=2 channel -> pattern emerges in order, 5 cycles late, with no duplicates or drops.
- Extremes: depth_sel=0 -> 1-cycle delay. depth_sel=31 -> 32-cycle delay. Run 100 wrap-arounds of random data against a reference queue model.
- Reload mid-stream: switch depth from 22 to 5 with ce=1 on the same edge -> primed drops next cycle. Old data is never output. Data written on the load edge appears after 6 enabled edges.
- Reset mid-operation: reset pulse while the line holds 10 valid pulses -> none of them ever appear on dout. The post-reset stream aligns at 23 cycles.
